// File: rtl/rx_block_lock_pkg.sv
// rtl/rx_block_lock_pkg.sv - shared lane state, default limits and sync-header check for rx_block_lock
package rx_block_lock_pkg;

    typedef enum logic [1:0] {
        LS_HUNT      = 2'd0,
        LS_SLIP_WAIT = 2'd1,
        LS_LOCKED    = 2'd2
    } lane_state_e;

    localparam int LP_LOCK_CNT_DEF = 64;
    localparam int LP_WIN_DEF      = 64;
    localparam int LP_BAD_MAX_DEF  = 16;
    localparam int LP_SLIP_GAP_DEF = 16;
    localparam int LP_STAT_W       = 16;

    // A 64b/66b sync header is legal only when its two bits differ.
    function automatic logic hdr_is_valid(input logic [1:0] hdr);
        return hdr[1] ^ hdr[0];
    endfunction

endpackage

// File: rtl/rx_block_lock_lane.sv
// rtl/rx_block_lock_lane.sv - single-lane 64b/66b block-lock FSM; RX_BLOCK_LOCK_STATS_EN adds slip/bad-header counters
module rx_block_lock_lane
    import rx_block_lock_pkg::*;
#(
    parameter int P_LOCK_CNT = LP_LOCK_CNT_DEF,
    parameter int P_WIN      = LP_WIN_DEF,
    parameter int P_BAD_MAX  = LP_BAD_MAX_DEF,
    parameter int P_SLIP_GAP = LP_SLIP_GAP_DEF
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] rxheader_i,
    input  logic       rxheadervalid_i,
    output logic       rxgearboxslip_o,
    output logic       locked_o,
    output logic       locked_nxt_o
`ifdef RX_BLOCK_LOCK_STATS_EN
    ,
    output logic [LP_STAT_W-1:0] slip_cnt_o,
    output logic [LP_STAT_W-1:0] bad_hdr_cnt_o
`endif
);

    localparam int SH_W  = $clog2(P_LOCK_CNT + 1);
    localparam int WIN_W = $clog2(P_WIN + 1);
    localparam int BAD_W = $clog2(P_BAD_MAX + 1);
    localparam int GAP_W = (P_SLIP_GAP < 1) ? 1 : $clog2(P_SLIP_GAP + 1);

    localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(P_LOCK_CNT - 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(P_WIN - 1);
    localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(P_BAD_MAX - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(P_SLIP_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    // With no settle time configured a slip returns straight to hunting.
    localparam lane_state_e ST_AFTER_SLIP = (P_SLIP_GAP == 0) ? LS_HUNT : LS_SLIP_WAIT;

    lane_state_e      r_state;
    logic [SH_W-1:0]  r_sh_cnt;
    logic [WIN_W-1:0] r_win_cnt;
    logic [BAD_W-1:0] r_bad_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_locked;
    logic             r_slip;

    lane_state_e      w_state_nxt;
    logic [SH_W-1:0]  w_sh_nxt;
    logic [WIN_W-1:0] w_win_nxt;
    logic [BAD_W-1:0] w_bad_nxt;
    logic [GAP_W-1:0] w_gap_nxt;
    logic             w_locked_nxt;
    logic             w_slip_nxt;
    logic             w_hdr_ok;

    assign w_hdr_ok = hdr_is_valid(rxheader_i);

    always_comb begin
        w_state_nxt  = r_state;
        w_sh_nxt     = r_sh_cnt;
        w_win_nxt    = r_win_cnt;
        w_bad_nxt    = r_bad_cnt;
        w_gap_nxt    = r_gap_cnt;
        w_locked_nxt = r_locked;
        w_slip_nxt   = 1'b0;
        if (rxheadervalid_i) begin
            case (r_state)
                LS_HUNT: begin
                    if (w_hdr_ok) begin
                        if (r_sh_cnt == SH_LAST) begin
                            w_state_nxt  = LS_LOCKED;
                            w_locked_nxt = 1'b1;
                            w_sh_nxt     = '0;
                        end else begin
                            w_sh_nxt = r_sh_cnt + SH_W'(1);
                        end
                    end else begin
                        w_sh_nxt    = '0;
                        w_slip_nxt  = 1'b1;
                        w_gap_nxt   = GAP_LOAD;
                        w_state_nxt = ST_AFTER_SLIP;
                    end
                end
                LS_SLIP_WAIT: begin
                    if (r_gap_cnt <= GAP_ONE) begin
                        w_gap_nxt   = '0;
                        w_state_nxt = LS_HUNT;
                    end else begin
                        w_gap_nxt = r_gap_cnt - GAP_W'(1);
                    end
                end
                LS_LOCKED: begin
                    // Loss of lock wins over a window boundary on the same strobe.
                    if (!w_hdr_ok && (r_bad_cnt == BAD_LAST)) begin
                        w_state_nxt  = ST_AFTER_SLIP;
                        w_locked_nxt = 1'b0;
                        w_slip_nxt   = 1'b1;
                        w_gap_nxt    = GAP_LOAD;
                        w_win_nxt    = '0;
                        w_bad_nxt    = '0;
                    end else if (r_win_cnt == WIN_LAST) begin
                        w_win_nxt = '0;
                        w_bad_nxt = '0;
                    end else begin
                        w_win_nxt = r_win_cnt + WIN_W'(1);
                        w_bad_nxt = r_bad_cnt + BAD_W'(!w_hdr_ok);
                    end
                end
                default: begin
                    w_state_nxt = LS_HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= LS_HUNT;
            r_sh_cnt  <= '0;
            r_win_cnt <= '0;
            r_bad_cnt <= '0;
            r_gap_cnt <= '0;
            r_locked  <= 1'b0;
            r_slip    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sh_cnt  <= w_sh_nxt;
            r_win_cnt <= w_win_nxt;
            r_bad_cnt <= w_bad_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_locked  <= w_locked_nxt;
            r_slip    <= w_slip_nxt;
        end
    end

    assign rxgearboxslip_o = r_slip;
    assign locked_o        = r_locked;
    assign locked_nxt_o    = rst_n_i & w_locked_nxt;

`ifdef RX_BLOCK_LOCK_STATS_EN
    logic [LP_STAT_W-1:0] r_slip_cnt;
    logic [LP_STAT_W-1:0] r_bad_hdr_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_slip_cnt    <= '0;
            r_bad_hdr_cnt <= '0;
        end else begin
            if (w_slip_nxt && (r_slip_cnt != '1)) begin
                r_slip_cnt <= r_slip_cnt + LP_STAT_W'(1);
            end
            if (rxheadervalid_i && (r_state == LS_LOCKED) && !w_hdr_ok
                    && (r_bad_hdr_cnt != '1)) begin
                r_bad_hdr_cnt <= r_bad_hdr_cnt + LP_STAT_W'(1);
            end
        end
    end

    assign slip_cnt_o    = r_slip_cnt;
    assign bad_hdr_cnt_o = r_bad_hdr_cnt;
`endif

endmodule

// File: rtl/rx_block_lock.sv
// rtl/rx_block_lock.sv - multi-lane 64b/66b block-lock top; RX_BLOCK_LOCK_STATS_EN adds per-lane stats ports
module rx_block_lock
    import rx_block_lock_pkg::*;
#(
    parameter int P_LANES    = 1,
    parameter int P_LOCK_CNT = LP_LOCK_CNT_DEF,
    parameter int P_WIN      = LP_WIN_DEF,
    parameter int P_BAD_MAX  = LP_BAD_MAX_DEF,
    parameter int P_SLIP_GAP = LP_SLIP_GAP_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [2*P_LANES-1:0]   rxheader_i,
    input  logic [P_LANES-1:0]     rxheadervalid_i,
    output logic [P_LANES-1:0]     rxgearboxslip_o,
    output logic [P_LANES-1:0]     locked_o,
    output logic                   all_locked_o
`ifdef RX_BLOCK_LOCK_STATS_EN
    ,
    output logic [16*P_LANES-1:0]  slip_cnt_o,
    output logic [16*P_LANES-1:0]  bad_hdr_cnt_o
`endif
);

    logic [P_LANES-1:0] w_slip;
    logic [P_LANES-1:0] w_locked;
    logic [P_LANES-1:0] w_locked_nxt;
    logic               r_all_locked;

    for (genvar g = 0; g < P_LANES; g++) begin : g_lane
        rx_block_lock_lane #(
            .P_LOCK_CNT (P_LOCK_CNT),
            .P_WIN      (P_WIN),
            .P_BAD_MAX  (P_BAD_MAX),
            .P_SLIP_GAP (P_SLIP_GAP)
        ) u_lane (
            .clk_i           (clk_i),
            .rst_n_i         (rst_n_i),
            .rxheader_i      (rxheader_i[2*g+1:2*g]),
            .rxheadervalid_i (rxheadervalid_i[g]),
            .rxgearboxslip_o (w_slip[g]),
            .locked_o        (w_locked[g]),
            .locked_nxt_o    (w_locked_nxt[g])
`ifdef RX_BLOCK_LOCK_STATS_EN
            ,
            .slip_cnt_o      (slip_cnt_o[16*g+15:16*g]),
            .bad_hdr_cnt_o   (bad_hdr_cnt_o[16*g+15:16*g])
`endif
        );
    end

    // Built from the lanes' next-state lock bits so it moves on the same edge as locked_o.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_all_locked <= 1'b0;
        end else begin
            r_all_locked <= &w_locked_nxt;
        end
    end

    assign rxgearboxslip_o = w_slip;
    assign locked_o        = w_locked;
    assign all_locked_o    = r_all_locked;

endmodule

// File: tb/tb_rx_block_lock.sv
// tb/tb_rx_block_lock.sv - scoreboard bench for rx_block_lock with four lanes and default limits
module tb_rx_block_lock;

    localparam int NL       = 4;
    localparam int LOCK_CNT = 64;
    localparam int WIN      = 64;
    localparam int BAD_MAX  = 16;
    localparam int GAP      = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2*NL-1:0] hdr = '0;
    logic [NL-1:0]   hv = '0;
    logic [NL-1:0]   slip;
    logic [NL-1:0]   locked;
    logic            all_locked;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] sb_q[$];
    logic [8:0] mon_exp;

    // Reference model: 0 hunting, 1 settling after a slip, 2 locked
    int         m_mode[NL];
    int         m_run[NL];
    int         m_gap[NL];
    int         m_win[NL];
    int         m_bad[NL];
    logic [NL-1:0] m_locked = '0;
    logic [NL-1:0] m_slip = '0;
    logic          m_all = 1'b0;

    int slip_at[$];
    int last_slip;

    always #5 clk = ~clk;

    rx_block_lock #(
        .P_LANES    (NL),
        .P_LOCK_CNT (LOCK_CNT),
        .P_WIN      (WIN),
        .P_BAD_MAX  (BAD_MAX),
        .P_SLIP_GAP (GAP)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .rxheader_i      (hdr),
        .rxheadervalid_i (hv),
        .rxgearboxslip_o (slip),
        .locked_o        (locked),
        .all_locked_o    (all_locked)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [1:0] h;
        logic       ok;
        m_slip = '0;
        for (int l = 0; l < NL; l++) begin
            h  = hdr[2*l +: 2];
            ok = (h == 2'b01) || (h == 2'b10);
            if (!rst_n) begin
                m_mode[l] = 0; m_run[l] = 0; m_gap[l] = 0; m_win[l] = 0; m_bad[l] = 0;
                m_locked[l] = 1'b0;
            end else if (hv[l]) begin
                if (m_mode[l] == 0) begin
                    if (ok) begin
                        m_run[l]++;
                        if (m_run[l] == LOCK_CNT) begin
                            m_mode[l] = 2; m_locked[l] = 1'b1; m_run[l] = 0;
                        end
                    end else begin
                        m_run[l] = 0; m_slip[l] = 1'b1; m_gap[l] = GAP; m_mode[l] = 1;
                    end
                end else if (m_mode[l] == 1) begin
                    m_gap[l]--;
                    if (m_gap[l] == 0) m_mode[l] = 0;
                end else begin
                    m_win[l]++;
                    if (!ok) m_bad[l]++;
                    if (m_bad[l] == BAD_MAX) begin
                        m_locked[l] = 1'b0; m_slip[l] = 1'b1; m_mode[l] = 1;
                        m_gap[l] = GAP; m_win[l] = 0; m_bad[l] = 0;
                    end else if (m_win[l] == WIN) begin
                        m_win[l] = 0; m_bad[l] = 0;
                    end
                end
            end
        end
        m_all = rst_n & (&m_locked);
    endtask

    // Drive one cycle of stimulus, queue the expected outputs, return once they are visible.
    task automatic step(input logic r, input logic [2*NL-1:0] h, input logic [NL-1:0] v);
        @(negedge clk);
        rst_n = r;
        hdr   = h;
        hv    = v;
        model_step();
        sb_q.push_back({m_slip, m_locked, m_all});
        @(posedge clk);
        #2;
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_exp = sb_q.pop_front();
            check_eq("out", {slip, locked, all_locked}, mon_exp);
        end
    end

    function automatic logic [1:0] rnd_hdr(input logic good);
        logic b;
        b = 1'($urandom_range(0, 1));
        return good ? {b, ~b} : {b, b};
    endfunction

    initial begin
        logic [NL-1:0]   seen_slip;
        logic [2*NL-1:0] hh;
        logic [NL-1:0]   vv;
        int              lim;

        // Reset with garbage on the inputs
        for (int i = 0; i < 4; i++) step(1'b0, 8'($urandom), 4'($urandom));
        check_eq("rst_locked", locked, 0);
        check_eq("rst_slip", slip, 0);
        check_eq("rst_all", all_locked, 0);

        // Clean headers on every lane every cycle
        seen_slip = '0;
        for (int i = 0; i < LOCK_CNT; i++) begin
            step(1'b1, 8'h55, 4'hF);
            seen_slip |= slip;
            if (i == LOCK_CNT - 2) check_eq("lock_early", locked, 0);
            if (i == LOCK_CNT - 1) begin
                check_eq("lock_64", locked, 4'hF);
                check_eq("all_64", all_locked, 1);
            end
        end
        check_eq("no_slip_clean", seen_slip, 0);

        // Lane 0: 15 bad in a window holds lock, 16 bad drops it
        for (int i = 0; i < WIN; i++) step(1'b1, (i < BAD_MAX - 1) ? 8'h57 : 8'h55, 4'hF);
        check_eq("hyst15_locked", locked, 4'hF);
        for (int i = 0; i < BAD_MAX; i++) begin
            step(1'b1, 8'h57, 4'hF);
            if (i == BAD_MAX - 2) check_eq("hyst16_pre", locked[0], 1);
        end
        check_eq("hyst16_unlock", locked[0], 0);
        check_eq("hyst16_slip", slip, 4'h1);
        check_eq("hyst16_all", all_locked, 0);
        step(1'b1, 8'h55, 4'hF);
        check_eq("slip_width", slip, 0);

        // Lane 0 stuck at 11 from reset: slips every 17 strobes, then relocks on 01
        step(1'b0, 8'h55, 4'hF);
        step(1'b0, 8'h55, 4'hF);
        slip_at.delete();
        for (int s = 0; s < 3 * (GAP + 1) + 1; s++) begin
            step(1'b1, 8'h57, 4'hF);
            if (slip[0]) slip_at.push_back(s);
        end
        check_eq("slip_count", slip_at.size(), 4);
        last_slip = 0;
        foreach (slip_at[k]) begin
            if (k > 0) check_eq("slip_spacing", slip_at[k] - last_slip, GAP + 1);
            last_slip = slip_at[k];
        end
        for (int s = 0; s < GAP + LOCK_CNT; s++) begin
            step(1'b1, 8'h55, 4'hF);
            if (s == GAP + LOCK_CNT - 2) check_eq("relock_early", locked[0], 0);
        end
        check_eq("relock", locked, 4'hF);

        // One strobe in three, bad headers on the idle cycles
        step(1'b0, 8'h55, 4'hF);
        for (int c = 0; c < 3 * LOCK_CNT - 2; c++) begin
            if (c % 3 == 0) step(1'b1, 8'h55, 4'hF);
            else            step(1'b1, 8'hFF, 4'h0);
            if (c == 3 * LOCK_CNT - 6) check_eq("sparse_early", locked, 0);
        end
        check_eq("sparse_lock", locked, 4'hF);
        check_eq("sparse_noslip", slip, 0);

        // Staggered lane start: all_locked waits for the last lane
        step(1'b0, 8'h55, 4'hF);
        for (int c = 0; c < 7 * (NL - 1) + LOCK_CNT + 4; c++) begin
            for (int l = 0; l < NL; l++) vv[l] = (c >= 7 * l);
            step(1'b1, 8'h55, vv);
            if (c == LOCK_CNT - 1) check_eq("stag_lane0", locked, 4'h1);
            if (c == 7 * (NL - 1) + LOCK_CNT - 2) check_eq("stag_all_pre", all_locked, 0);
            if (c == 7 * (NL - 1) + LOCK_CNT - 1) check_eq("stag_all", all_locked, 1);
        end

        // Mid-run reset clears everything on the next edge
        step(1'b0, 8'h57, 4'hF);
        check_eq("midrst_locked", locked, 0);
        check_eq("midrst_all", all_locked, 0);
        check_eq("midrst_slip", slip, 0);

        // Random headers with lane-dependent error rates and rare resets
        for (int c = 0; c < 1500; c++) begin
            for (int l = 0; l < NL; l++) begin
                lim = (32 >> l) - 1;
                vv[l] = ($urandom_range(0, 3) != 0);
                hh[2*l +: 2] = rnd_hdr($urandom_range(0, lim) != 0);
            end
            step(($urandom_range(0, 499) != 0), hh, vv);
        end

        repeat (3) @(posedge clk);
        #2;
        check_eq("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
